// File: rtl/pc_fetch_unit.sv
// Program counter plus req/ack instruction-fetch sequencer for the multi-cycle CPU.
// Misaligned fetch addresses and memory timeouts lock the unit in S_ERR until reset.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCWre,
  input  logic [31:0] NewPC,
  input  logic        FetchStart,
  input  logic        Halt,
  input  logic [31:0] InsMemRdata,
  input  logic        InsMemAck,
  output logic [31:0] PCOut,
  output logic [31:0] PCPlus4,
  output logic [31:0] InsMemAddr,
  output logic        InsMemReq,
  output logic [31:0] IR,
  output logic        IRValid,
  output logic        FetchBusy,
  output logic        FetchErr,
  output logic        PCWreDropped
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [31:0] pc_nxt, addr_nxt, ir_nxt;
  logic        req_nxt, irv_nxt, err_nxt, drop_nxt;
  logic [31:0] fetch_addr;

  assign PCPlus4   = PCOut + 32'd4;
  assign FetchBusy = (state == S_REQ);
  // A fetch issued together with a PC load targets the newly loaded PC.
  assign fetch_addr = PCWre ? NewPC : PCOut;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state        <= S_IDLE;
      cnt          <= 8'd0;
      PCOut        <= RESET_PC;
      InsMemAddr   <= 32'd0;
      IR           <= 32'd0;
      InsMemReq    <= 1'b0;
      IRValid      <= 1'b0;
      FetchErr     <= 1'b0;
      PCWreDropped <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      PCOut        <= pc_nxt;
      InsMemAddr   <= addr_nxt;
      IR           <= ir_nxt;
      InsMemReq    <= req_nxt;
      IRValid      <= irv_nxt;
      FetchErr     <= err_nxt;
      PCWreDropped <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pc_nxt    = PCOut;
    addr_nxt  = InsMemAddr;
    ir_nxt    = IR;
    req_nxt   = InsMemReq;
    irv_nxt   = 1'b0;
    err_nxt   = FetchErr;
    drop_nxt  = PCWreDropped;

    case (state)
      S_IDLE: begin
        if (!Halt) begin
          if (PCWre) pc_nxt = NewPC;
          if (FetchStart) begin
            if (fetch_addr[1:0] != 2'b00) begin
              state_nxt = S_ERR;
              err_nxt   = 1'b1;
            end else begin
              addr_nxt  = fetch_addr;
              req_nxt   = 1'b1;
              cnt_nxt   = 8'd0;
              state_nxt = S_REQ;
            end
          end
        end
      end
      S_REQ: begin
        if (PCWre) drop_nxt = 1'b1;
        // An ack on the final allowed cycle still completes the fetch.
        if (InsMemAck) begin
          ir_nxt    = InsMemRdata;
          req_nxt   = 1'b0;
          irv_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end else if (cnt == CNT_LAST) begin
          req_nxt   = 1'b0;
          err_nxt   = 1'b1;
          state_nxt = S_ERR;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      S_ERR: begin
        req_nxt = 1'b0;
      end
      default: begin
        state_nxt = S_IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed and randomized checks of pc_fetch_unit against a transaction-level model.
module tb_pc_fetch_unit;
  localparam int TIMEOUT = 16;

  logic        CLK = 1'b0;
  logic        Reset, PCWre, FetchStart, Halt, InsMemAck;
  logic [31:0] NewPC, InsMemRdata;
  logic [31:0] PCOut, PCPlus4, InsMemAddr, IR;
  logic        InsMemReq, IRValid, FetchBusy, FetchErr, PCWreDropped;

  int tests = 0;
  int fails = 0;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .Reset(Reset), .PCWre(PCWre), .NewPC(NewPC),
    .FetchStart(FetchStart), .Halt(Halt), .InsMemRdata(InsMemRdata),
    .InsMemAck(InsMemAck), .PCOut(PCOut), .PCPlus4(PCPlus4),
    .InsMemAddr(InsMemAddr), .InsMemReq(InsMemReq), .IR(IR),
    .IRValid(IRValid), .FetchBusy(FetchBusy), .FetchErr(FetchErr),
    .PCWreDropped(PCWreDropped)
  );

  always #5 CLK = ~CLK;

  // Reference model: a fetch is either outstanding (with a wait count), or not, or the unit is dead.
  bit          m_dead, m_busy, m_irv, m_err, m_drop;
  int          m_waited;
  logic [31:0] m_pc, m_addr, m_ir;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_dead = 0; m_busy = 0; m_irv = 0; m_err = 0; m_drop = 0;
    m_waited = 0; m_pc = 32'h0; m_addr = 32'h0; m_ir = 32'h0;
  endtask

  task automatic model_next();
    logic [31:0] a;
    m_irv = 0;
    if (m_dead) begin
      // everything frozen
    end else if (m_busy) begin
      if (PCWre) m_drop = 1;
      if (InsMemAck) begin
        m_ir = InsMemRdata; m_irv = 1; m_busy = 0;
      end else begin
        m_waited++;
        if (m_waited == TIMEOUT) begin
          m_busy = 0; m_dead = 1; m_err = 1;
        end
      end
    end else if (!Halt) begin
      a = PCWre ? NewPC : m_pc;
      if (PCWre) m_pc = NewPC;
      if (FetchStart) begin
        if (a % 4 != 0) begin
          m_dead = 1; m_err = 1;
        end else begin
          m_addr = a; m_busy = 1; m_waited = 0;
        end
      end
    end
  endtask

  task automatic check_model();
    chk("PCOut", PCOut, m_pc);
    chk("PCPlus4", PCPlus4, m_pc + 32'd4);
    chk("InsMemAddr", InsMemAddr, m_addr);
    chk("IR", IR, m_ir);
    chk("IRValid", 32'(IRValid), 32'(m_irv));
    chk("InsMemReq", 32'(InsMemReq), 32'(m_busy));
    chk("FetchBusy", 32'(FetchBusy), 32'(m_busy));
    chk("FetchErr", 32'(FetchErr), 32'(m_err));
    chk("PCWreDropped", 32'(PCWreDropped), 32'(m_drop));
  endtask

  task automatic idle_inputs();
    PCWre = 0; NewPC = 32'h0; FetchStart = 0; Halt = 0;
    InsMemAck = 0; InsMemRdata = 32'h0;
  endtask

  task automatic cycle();
    model_next();
    @(posedge CLK);
    #1;
    check_model();
  endtask

  // Called 1 time unit after an edge; reset takes effect without waiting for a clock.
  task automatic do_reset();
    Reset = 1'b1;
    #2;
    model_reset();
    check_model();
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    idle_inputs();
    check_model();
  endtask

  initial begin
    int busy_cnt;
    int req_cnt;
    logic [31:0] ir_before;

    idle_inputs();
    Reset = 1'b1;
    model_reset();
    #3;
    check_model();
    @(posedge CLK);
    #1;
    Reset = 1'b0;

    // Reset release and a single fetch acked in its first request cycle
    chk("rst_pc", PCOut, 32'h0);
    chk("rst_pc4", PCPlus4, 32'h4);
    FetchStart = 1;
    cycle();
    FetchStart = 0;
    chk("f1_addr", InsMemAddr, 32'h0);
    chk("f1_req", 32'(InsMemReq), 32'd1);
    InsMemAck = 1; InsMemRdata = 32'h2001_0005;
    cycle();
    InsMemAck = 0;
    chk("f1_ir", IR, 32'h2001_0005);
    chk("f1_irv", 32'(IRValid), 32'd1);
    // back-to-back fetch issued while IRValid is high
    FetchStart = 1;
    cycle();
    FetchStart = 0;
    chk("b2b_irv_drop", 32'(IRValid), 32'd0);
    chk("b2b_busy", 32'(FetchBusy), 32'd1);
    InsMemAck = 1; InsMemRdata = 32'hCAFE_0001;
    cycle();
    InsMemAck = 0;
    chk("b2b_ir", IR, 32'hCAFE_0001);

    // PC load plus fetch in the same cycle, three wait cycles
    PCWre = 1; NewPC = 32'h40; FetchStart = 1;
    cycle();
    idle_inputs();
    chk("ld_pc", PCOut, 32'h40);
    chk("ld_addr", InsMemAddr, 32'h40);
    busy_cnt = 32'(FetchBusy);
    for (int i = 0; i < 3; i++) begin
      cycle();
      busy_cnt += 32'(FetchBusy);
    end
    InsMemAck = 1; InsMemRdata = 32'h1234_5678;
    cycle();
    InsMemAck = 0;
    chk("ld_busy_cycles", 32'(busy_cnt), 32'd4);
    chk("ld_ir", IR, 32'h1234_5678);

    // Halt in idle ignores PCWre and FetchStart without flagging a drop
    Halt = 1; PCWre = 1; NewPC = 32'h80; FetchStart = 1;
    cycle();
    idle_inputs();
    chk("halt_pc", PCOut, 32'h40);
    chk("halt_drop", 32'(PCWreDropped), 32'd0);
    chk("halt_busy", 32'(FetchBusy), 32'd0);

    // PCWre during an outstanding fetch is dropped and flagged
    FetchStart = 1;
    cycle();
    FetchStart = 0;
    PCWre = 1; NewPC = 32'h80; Halt = 1;
    cycle();
    idle_inputs();
    chk("drop_pc", PCOut, 32'h40);
    chk("drop_flag", 32'(PCWreDropped), 32'd1);
    InsMemAck = 1; InsMemRdata = 32'h0BAD_F00D;
    cycle();
    InsMemAck = 0;
    chk("drop_ir", IR, 32'h0BAD_F00D);

    // Timeout: no ack for TIMEOUT request cycles
    ir_before = IR;
    FetchStart = 1;
    cycle();
    FetchStart = 0;
    req_cnt = 0;
    for (int i = 0; i < 40 && !FetchErr; i++) begin
      req_cnt += 32'(InsMemReq);
      cycle();
    end
    chk("to_req_cycles", 32'(req_cnt), 32'(TIMEOUT));
    chk("to_err", 32'(FetchErr), 32'd1);
    chk("to_req_low", 32'(InsMemReq), 32'd0);
    chk("to_ir_kept", IR, ir_before);
    do_reset();

    // Misaligned fetch goes straight to the error state
    PCWre = 1; NewPC = 32'h42;
    cycle();
    idle_inputs();
    chk("mis_pc", PCOut, 32'h42);
    FetchStart = 1;
    cycle();
    FetchStart = 0;
    chk("mis_err", 32'(FetchErr), 32'd1);
    chk("mis_req", 32'(InsMemReq), 32'd0);
    PCWre = 1; NewPC = 32'h100; FetchStart = 1; InsMemAck = 1; InsMemRdata = 32'hFFFF_0000;
    for (int i = 0; i < 3; i++) cycle();
    idle_inputs();
    chk("err_pc_frozen", PCOut, 32'h42);
    chk("err_ir_frozen", IR, 32'h0);
    chk("err_drop", 32'(PCWreDropped), 32'd0);
    do_reset();

    // Reset in the middle of a request
    FetchStart = 1;
    cycle();
    FetchStart = 0;
    cycle();
    chk("mid_req_before", 32'(InsMemReq), 32'd1);
    do_reset();
    chk("mid_req_after", 32'(InsMemReq), 32'd0);

    // PC wrap at the top of the address space
    PCWre = 1; NewPC = 32'hFFFF_FFFC;
    cycle();
    idle_inputs();
    chk("wrap_pc4", PCPlus4, 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      if (m_dead || ($urandom % 150) == 0) begin
        do_reset();
      end else begin
        PCWre       = ($urandom % 4) == 0;
        NewPC       = (32'($urandom % 256) << 2) | ((($urandom % 20) == 0) ? 32'h2 : 32'h0);
        FetchStart  = ($urandom % 3) == 0;
        Halt        = ($urandom % 6) == 0;
        InsMemAck   = ($urandom % 3) == 0;
        InsMemRdata = $urandom;
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter register and instruction-fetch sequencer for the multi-cycle CPU. It holds the PC, provides PCOut and PCPlus4 to the next-PC selection logic, and loads the NewPC it gets back. On command from the control unit it runs a req/ack fetch from instruction memory and latches the result into the instruction register (IR). Misaligned addresses and memory timeouts are detected and reported.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
TIMEOUT, 16, maximum cycles spent in S_REQ without InsMemAck before the error state; legal range 1..255.

Ports:
CLK  in  1  clock, all state updates on the rising edge
Reset  in  1  asynchronous, active-high reset
PCWre  in  1  load NewPC into the PC this cycle
NewPC  in  32  next PC from the next-PC selection logic
FetchStart  in  1  control unit requests an instruction fetch
Halt  in  1  freezes PC loads and new fetches
InsMemRdata  in  32  instruction word from instruction memory
InsMemAck  in  1  instruction memory data valid
PCOut  out  32  current PC, byte address
PCPlus4  out  32  PCOut + 4, combinational
InsMemAddr  out  32  fetch address, registered
InsMemReq  out  1  fetch request, held until ack
IR  out  32  instruction register
IRValid  out  1  one-cycle pulse when IR has been updated
FetchBusy  out  1  high while in S_REQ
FetchErr  out  1  sticky error flag
PCWreDropped  out  1  sticky flag: a PCWre was ignored

Behaviour:
- Reset, asynchronous and immediate, including mid-fetch:
  - PCOut = RESET_PC; InsMemAddr = 0; IR = 0.
  - InsMemReq, IRValid, FetchErr, PCWreDropped, FetchBusy = 0.
  - state = S_IDLE; timeout counter = 0.
- PCPlus4 = PCOut + 32'd4, modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- States: S_IDLE, S_REQ, S_ERR.
- S_IDLE with Halt = 0:
  - PCWre = 1: PCOut <= NewPC next edge.
  - FetchStart = 1: fetch address A = PCWre ? NewPC : PCOut. Both may be asserted in the same cycle; the fetch then uses NewPC.
  - If A[1:0] != 0: go to S_ERR, FetchErr <= 1, no request issued.
  - Otherwise: InsMemAddr <= A, InsMemReq <= 1, counter <= 0, go to S_REQ.
- S_IDLE with Halt = 1: PCWre and FetchStart are ignored; this does not set PCWreDropped. State and outputs hold.
- S_REQ:
  - InsMemReq = 1; InsMemAddr stable.
  - On InsMemAck = 1: IR <= InsMemRdata, InsMemReq <= 0, IRValid <= 1 for exactly the next cycle, go to S_IDLE.
  - Otherwise counter increments each cycle. When counter reaches TIMEOUT-1 without an ack: go to S_ERR, FetchErr <= 1, InsMemReq <= 0, IR unchanged.
  - Halt has no effect; an in-flight fetch completes.
  - PCWre is ignored and sets PCWreDropped (sticky). FetchStart is ignored.
  - Ack-to-IR latency: IR and IRValid are visible the cycle after the ack edge. With ack in the first S_REQ cycle, IRValid appears 2 cycles after FetchStart.
- S_ERR: absorbing until Reset. PC, IR and InsMemAddr are frozen; PCWre, FetchStart and InsMemAck are ignored; InsMemReq = 0.
- InsMemAck outside S_REQ is ignored.
- Back-to-back fetches: FetchStart may be asserted in the same cycle IRValid = 1 (the state is S_IDLE).
- FetchBusy = (state == S_REQ).

Test Plan:
- Reset release, RESET_PC = 0: PCOut = 0, PCPlus4 = 4. FetchStart for 1 cycle, ack on the first S_REQ cycle with data 32'h2001_0005 -> InsMemAddr = 0, IR = 32'h2001_0005, IRValid high for exactly 1 cycle, 2 cycles after FetchStart.
- PCWre with NewPC = 32'h0000_0040 and FetchStart in the same cycle -> PCOut = 0x40, InsMemAddr = 0x40. Ack after 3 wait cycles -> IR captured; FetchBusy high for 4 cycles.
- FetchStart with PCOut = 32'h0000_0042 -> S_ERR and FetchErr = 1 next cycle, InsMemReq never asserted. Later PCWre, FetchStart and ack are all ignored until Reset.
- TIMEOUT = 16, no ack -> InsMemReq high for 16 cycles, then FetchErr = 1, InsMemReq = 0, IR keeps its prior value.
- PCWre with NewPC = 0x80 pulsed during S_REQ -> PCOut unchanged, PCWreDropped = 1. Halt = 1 in S_IDLE with PCWre -> PCOut unchanged, PCWreDropped not set.
- Reset asserted mid-S_REQ -> InsMemReq drops before the next edge and PCOut = RESET_PC. PCOut = 32'hFFFF_FFFC -> PCPlus4 = 0.
